// File: rtl/music_player_if.sv
// Control, score and status bundle between the score editor side and the
// music player. The loop-enable level is called repeat_mode because
// "repeat" is a reserved word in SystemVerilog.
interface music_player_if;
  logic         play;
  logic         stop;
  logic         pause;
  logic         repeat_mode;
  logic [300:0] rhyme;
  logic [300:0] md;
  logic [7:0]   how_long;
  logic         buzzer;
  logic         playing;
  logic [7:0]   play_position;
  logic [3:0]   cur_note;
  logic [3:0]   cur_md;
  logic         done;

  modport master (
    output play, stop, pause, repeat_mode, rhyme, md, how_long,
    input  buzzer, playing, play_position, cur_note, cur_md, done
  );

  modport slave (
    input  play, stop, pause, repeat_mode, rhyme, md, how_long,
    output buzzer, playing, play_position, cur_note, cur_md, done
  );
endinterface

// File: rtl/music_player.sv
// Score playback: walks the packed score one slot per NOTE_CYCLES, sounding
// a square wave for the first part of each slot and silencing the buzzer
// for the last GAP_CYCLES so repeated notes stay distinct.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | not playing, outputs parked at 0
// TONE  | slot sounding, half-period counter drives buzzer
// GAP   | tail of slot, buzzer held low
module music_player #(
  parameter int NOTE_CYCLES = 16_666_667,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int TONE_SHIFT  = 0
) (
  input  logic          clk100mhz,
  input  logic          clr,
  music_player_if.slave bus
);

  localparam int          MAX_SLOTS = 75;
  localparam logic [24:0] SLOT_LAST = 25'(NOTE_CYCLES - 1);
  localparam logic [24:0] TONE_LAST = 25'(NOTE_CYCLES - GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state;
  logic [24:0] slot_cnt;
  logic [19:0] half_cnt;
  logic        buzzer_q;
  logic        playing_q;
  logic [7:0]  play_position_q;
  logic [3:0]  cur_note_q;
  logic [3:0]  cur_md_q;
  logic        done_q;

  logic [7:0]  len;
  logic        last_slot;
  logic [7:0]  next_pos;
  logic [3:0]  next_note;
  logic [3:0]  next_md;
  logic        tone_on;
  logic [19:0] base_half;
  logic [19:0] oct_half;
  logic [19:0] shifted_half;
  logic [19:0] half_last;

  // Only 75 complete nibbles exist in the 301-bit score; the top bit is dead.
  logic unused_bits;
  assign unused_bits = ^{bus.rhyme[300], bus.md[300]};

  assign len       = (bus.how_long > 8'(MAX_SLOTS)) ? 8'(MAX_SLOTS) : bus.how_long;
  assign last_slot = ({1'b0, play_position_q} + 9'd1) >= {1'b0, len};

  // Fetch the slot that follows the current one, for the end-of-slot advance.
  always_comb begin
    next_pos  = play_position_q + 8'd1;
    next_note = 4'd0;
    next_md   = 4'd0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (next_pos == 8'(i)) begin
        next_note = bus.rhyme[4*i +: 4];
        next_md   = bus.md[4*i +: 4];
      end
    end
  end

  // Half-period lookup for the latched note, octave scaling, then sim shrink.
  always_comb begin
    base_half = 20'd0;
    tone_on   = 1'b1;
    case (cur_note_q)
      4'd1:    base_half = 20'd190840;
      4'd2:    base_half = 20'd170068;
      4'd3:    base_half = 20'd151515;
      4'd4:    base_half = 20'd143266;
      4'd5:    base_half = 20'd127551;
      4'd6:    base_half = 20'd113636;
      4'd7:    base_half = 20'd101215;
      default: tone_on   = 1'b0;
    endcase
    oct_half = base_half;
    case (cur_md_q)
      4'd1:    oct_half = base_half << 1;
      4'd2:    oct_half = base_half >> 1;
      default: oct_half = base_half;
    endcase
    shifted_half = oct_half >> TONE_SHIFT;
    // A period that shrinks to zero is played as the shortest legal one.
    half_last = (shifted_half == 20'd0) ? 20'd0 : shifted_half - 20'd1;
  end

  // Playback sequencer: stop beats play beats pause; all outputs registered.
  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      state           <= IDLE;
      slot_cnt        <= '0;
      half_cnt        <= '0;
      buzzer_q        <= 1'b0;
      playing_q       <= 1'b0;
      play_position_q <= '0;
      cur_note_q      <= '0;
      cur_md_q        <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state           <= IDLE;
        slot_cnt        <= '0;
        half_cnt        <= '0;
        buzzer_q        <= 1'b0;
        playing_q       <= 1'b0;
        play_position_q <= '0;
        cur_note_q      <= '0;
        cur_md_q        <= '0;
      end else if (bus.play) begin
        slot_cnt        <= '0;
        half_cnt        <= '0;
        buzzer_q        <= 1'b0;
        play_position_q <= '0;
        if (len == 8'd0) begin
          // Nothing to play: report an empty pass and stay parked.
          state      <= IDLE;
          playing_q  <= 1'b0;
          cur_note_q <= '0;
          cur_md_q   <= '0;
          done_q     <= 1'b1;
        end else begin
          state      <= TONE;
          playing_q  <= 1'b1;
          cur_note_q <= bus.rhyme[3:0];
          cur_md_q   <= bus.md[3:0];
        end
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          TONE, GAP: begin
            if (bus.pause) begin
              // Counters freeze; the tone resumes from the held phase but low.
              buzzer_q <= 1'b0;
            end else if (slot_cnt == SLOT_LAST) begin
              slot_cnt <= '0;
              half_cnt <= '0;
              buzzer_q <= 1'b0;
              if (!last_slot) begin
                state           <= TONE;
                play_position_q <= next_pos;
                cur_note_q      <= next_note;
                cur_md_q        <= next_md;
              end else begin
                done_q          <= 1'b1;
                play_position_q <= '0;
                if (bus.repeat_mode) begin
                  state      <= TONE;
                  cur_note_q <= bus.rhyme[3:0];
                  cur_md_q   <= bus.md[3:0];
                end else begin
                  state      <= IDLE;
                  playing_q  <= 1'b0;
                  cur_note_q <= '0;
                  cur_md_q   <= '0;
                end
              end
            end else begin
              slot_cnt <= slot_cnt + 25'd1;
              if (state == TONE && slot_cnt != TONE_LAST) begin
                if (!tone_on) begin
                  buzzer_q <= 1'b0;
                  half_cnt <= '0;
                end else if (half_cnt == half_last) begin
                  buzzer_q <= ~buzzer_q;
                  half_cnt <= '0;
                end else begin
                  half_cnt <= half_cnt + 20'd1;
                end
              end else begin
                state    <= GAP;
                buzzer_q <= 1'b0;
                half_cnt <= '0;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.buzzer        = buzzer_q;
  assign bus.playing       = playing_q;
  assign bus.play_position = play_position_q;
  assign bus.cur_note      = cur_note_q;
  assign bus.cur_md        = cur_md_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with shortened slot timing.
`timescale 1ns/1ps
module tb_music_player;
  localparam int NC = 600;
  localparam int GC = 60;
  localparam int TS = 10;
  localparam int TONE_SAMPLES = NC - GC - 1;

  logic clk100mhz = 1'b0;
  logic clr = 1'b0;
  always #5 clk100mhz = ~clk100mhz;

  music_player_if bus();

  music_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .TONE_SHIFT(TS)) dut (
    .clk100mhz (clk100mhz),
    .clr       (clr),
    .bus       (bus)
  );

  int cyc = 0;
  int dcount = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] note;
    logic [3:0] m;
    int         exp_h;
  } vec_t;
  vec_t vecs[12];

  task automatic tick();
    @(posedge clk100mhz);
    #1;
    cyc++;
    if (bus.done) dcount++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_play(output int e);
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
    e = cyc;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  // Cycles from slot entry until the buzzer first goes high; 0 if never in TONE.
  task automatic first_high(output int n);
    n = 0;
    for (int k = 1; k <= TONE_SAMPLES; k++) begin
      tick();
      if (bus.buzzer) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic set_slot(input int i, input logic [3:0] note, input logic [3:0] m);
    bus.rhyme[4*i +: 4] = note;
    bus.md[4*i +: 4]    = m;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, n, highs, toggles, t1, t2, d0;
    logic prev;

    vecs[0]  = '{4'd1, 4'd0, 186};
    vecs[1]  = '{4'd2, 4'd0, 166};
    vecs[2]  = '{4'd3, 4'd1, 295};
    vecs[3]  = '{4'd4, 4'd2, 69};
    vecs[4]  = '{4'd5, 4'd2, 62};
    vecs[5]  = '{4'd6, 4'd1, 221};
    vecs[6]  = '{4'd6, 4'd0, 110};
    vecs[7]  = '{4'd6, 4'd2, 55};
    vecs[8]  = '{4'd7, 4'd0, 98};
    vecs[9]  = '{4'd1, 4'd5, 186};
    vecs[10] = '{4'd0, 4'd0, 0};
    vecs[11] = '{4'd8, 4'd1, 0};

    bus.play = 0; bus.stop = 0; bus.pause = 0; bus.repeat_mode = 0;
    bus.rhyme = '0; bus.md = '0; bus.how_long = 8'd0;

    // Reset values
    repeat (3) tick();
    check("rst_playing", bus.playing, 0);
    check("rst_buzzer", bus.buzzer, 0);
    check("rst_pos", bus.play_position, 0);
    check("rst_note", bus.cur_note, 0);
    check("rst_done", bus.done, 0);
    clr = 1'b1;
    tick();

    // Half-period table, one single-slot play per vector
    foreach (vecs[v]) begin
      bus.rhyme = '0; bus.md = '0;
      set_slot(0, vecs[v].note, vecs[v].m);
      bus.how_long = 8'd1;
      pulse_play(e);
      check($sformatf("vec%0d_note", v), bus.cur_note, vecs[v].note);
      check($sformatf("vec%0d_md", v), bus.cur_md, vecs[v].m);
      check($sformatf("vec%0d_playing", v), bus.playing, 1);
      first_high(n);
      check($sformatf("vec%0d_half", v), n, vecs[v].exp_h);
      pulse_stop();
      check($sformatf("vec%0d_stopped", v), bus.playing, 0);
    end

    // Timing of one full slot: two toggles in TONE, silent GAP, done at 600
    bus.rhyme = '0; bus.md = '0;
    set_slot(0, 4'd1, 4'd0);
    bus.how_long = 8'd1;
    d0 = dcount;
    pulse_play(e);
    check("tim_entry_buz", bus.buzzer, 0);
    check("tim_entry_pos", bus.play_position, 0);
    prev = bus.buzzer; toggles = 0; t1 = 0; t2 = 0;
    for (int k = 1; k <= TONE_SAMPLES; k++) begin
      tick();
      if (bus.buzzer !== prev) begin
        toggles++;
        if (toggles == 1) t1 = k;
        if (toggles == 2) t2 = k;
      end
      prev = bus.buzzer;
    end
    check("tim_toggles", toggles, 2);
    check("tim_t1", t1, 186);
    check("tim_t2", t2, 372);
    highs = 0;
    while (cyc < e + NC - 1) begin
      tick();
      if (bus.buzzer) highs++;
    end
    check("tim_gap_low", highs, 0);
    check("tim_no_early_done", dcount - d0, 0);
    tick();
    check("tim_done", bus.done, 1);
    check("tim_playing_fall", bus.playing, 0);
    tick();
    check("tim_done_pulse", bus.done, 0);

    // Octaves across three slots
    bus.rhyme = '0; bus.md = '0;
    set_slot(0, 4'd6, 4'd1);
    set_slot(1, 4'd6, 4'd0);
    set_slot(2, 4'd6, 4'd2);
    bus.how_long = 8'd3;
    pulse_play(e);
    for (int s = 0; s < 3; s++) begin
      run_to(e + NC*s);
      check($sformatf("oct%0d_pos", s), bus.play_position, s);
      first_high(n);
      check($sformatf("oct%0d_half", s), n, (s == 0) ? 221 : (s == 1) ? 110 : 55);
    end
    run_to(e + 3*NC);
    check("oct_done", bus.done, 1);
    check("oct_end_playing", bus.playing, 0);

    // Rest slot and length clamp to 75
    bus.rhyme = '0; bus.md = '0;
    for (int i = 0; i < 75; i++) set_slot(i, 4'd1, 4'd0);
    bus.rhyme[300] = 1'b1;
    set_slot(1, 4'd0, 4'd0);
    bus.how_long = 8'd200;
    d0 = dcount;
    pulse_play(e);
    run_to(e + NC);
    check("rest_pos", bus.play_position, 1);
    highs = 0;
    while (cyc < e + 2*NC - 1) begin
      tick();
      if (bus.buzzer) highs++;
    end
    check("rest_silent", highs, 0);
    run_to(e + 74*NC);
    check("clamp_pos74", bus.play_position, 74);
    check("clamp_playing", bus.playing, 1);
    check("clamp_no_early_done", dcount - d0, 0);
    run_to(e + 75*NC);
    check("clamp_done", bus.done, 1);
    check("clamp_idle", bus.playing, 0);

    // Repeat with live edit and pause
    bus.rhyme = '0; bus.md = '0;
    set_slot(0, 4'd1, 4'd0);
    set_slot(1, 4'd2, 4'd0);
    bus.how_long = 8'd2;
    bus.repeat_mode = 1'b1;
    pulse_play(e);
    run_to(e + 10);
    set_slot(0, 4'd3, 4'd0);
    tick();
    check("edit_not_live", bus.cur_note, 1);
    run_to(e + 2*NC);
    check("rep_done", bus.done, 1);
    check("rep_wrap_pos", bus.play_position, 0);
    check("rep_playing", bus.playing, 1);
    check("rep_new_note", bus.cur_note, 3);
    e2 = cyc;
    run_to(e2 + 100);
    bus.pause = 1'b1;
    highs = 0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (bus.buzzer) highs++;
    end
    bus.pause = 1'b0;
    check("pause_silent", highs, 0);
    check("pause_pos_held", bus.play_position, 0);
    run_to(e2 + NC + 499);
    check("pause_slot_late", bus.play_position, 0);
    tick();
    check("pause_slot_end", bus.play_position, 1);

    // Stop mid-slot: idle next cycle, no done
    run_to(e2 + NC + 700);
    d0 = dcount;
    pulse_stop();
    check("stop_playing", bus.playing, 0);
    check("stop_pos", bus.play_position, 0);
    check("stop_buzzer", bus.buzzer, 0);
    check("stop_note", bus.cur_note, 0);
    check("stop_done", bus.done, 0);
    repeat (10) tick();
    check("stop_no_done", dcount - d0, 0);
    bus.repeat_mode = 1'b0;

    // Restart mid-slot-3, then async reset mid-TONE
    bus.rhyme = '0; bus.md = '0;
    for (int i = 0; i < 5; i++) set_slot(i, 4'(i + 1), 4'd0);
    bus.how_long = 8'd5;
    pulse_play(e);
    run_to(e + 3*NC + 250);
    check("rs_pos3", bus.play_position, 3);
    check("rs_note3", bus.cur_note, 4);
    d0 = dcount;
    pulse_play(e);
    check("rs_pos0", bus.play_position, 0);
    check("rs_note0", bus.cur_note, 1);
    check("rs_playing", bus.playing, 1);
    check("rs_no_done", dcount - d0, 0);
    run_to(e + 200);
    check("pre_rst_buzzer", bus.buzzer, 1);
    clr = 1'b0;
    #2;
    check("arst_playing", bus.playing, 0);
    check("arst_buzzer", bus.buzzer, 0);
    check("arst_pos", bus.play_position, 0);
    check("arst_note", bus.cur_note, 0);
    tick();
    clr = 1'b1;
    tick();

    // Zero length
    bus.how_long = 8'd0;
    pulse_play(e);
    check("zero_done", bus.done, 1);
    check("zero_playing", bus.playing, 0);
    check("zero_buzzer", bus.buzzer, 0);
    tick();
    check("zero_done_pulse", bus.done, 0);
    check("zero_still_idle", bus.playing, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Playback stage directly downstream of the score editor.
- Consumes the editor's packed score: rhyme (4-bit note per slot), md (4-bit octave modifier per slot) and how_long (used length).
- Steps through slots at a fixed note tempo and drives a square-wave tone on the buzzer pin.
- Runs entirely in the 100 MHz domain; the note tick is derived internally.

Parameters:
- NOTE_CYCLES, 16_666_667: clk100mhz cycles per note slot (6 notes/s); legal range 8..2^25-1.
- GAP_CYCLES, 1_000_000: cycles at the end of each slot with the buzzer forced low (articulation); must be < NOTE_CYCLES.
- TONE_SHIFT, 0: right-shift applied to every tone half-period. Used only to shrink periods in simulation.

Ports:
- clk100mhz  in  1  system clock
- clr  in  1  asynchronous active-low reset
- play  in  1  1-cycle pulse: start playback from slot 0
- stop  in  1  level/pulse: abort playback
- pause  in  1  level: freeze playback while high
- repeat  in  1  level: loop to slot 0 at end of score
- rhyme  in  301  packed notes; slot i = rhyme[4i+3:4i]; 0 = rest, 1..7 = do..ti
- md  in  301  packed modifiers; slot i = md[4i+3:4i]; 1 = low octave, 2 = high octave, other = middle
- how_long  in  8  number of valid slots
- buzzer  out  1  square-wave tone output
- playing  out  1  high while not IDLE
- play_position  out  8  slot currently sounding
- cur_note  out  4  latched note of current slot
- cur_md  out  4  latched modifier of current slot
- done  out  1  1-cycle pulse at end of each pass

Behaviour:
- Reset (clr low, async):
  - State IDLE; all outputs 0; all counters 0.
- Effective length: len = min(how_long, 75). Only the 75 full nibbles, bits 299:0, are playable; bit 300 is ignored.
- Priority per cycle: stop > play > pause.
- States:
  - IDLE
  - TONE: buzzer active.
  - GAP: buzzer forced 0.
- IDLE + play:
  - If len == 0: stay IDLE and pulse done next cycle.
  - Otherwise, next cycle: state TONE, play_position = 0, cur_note/cur_md latched from slot 0, playing = 1, buzzer = 0, slot counter = 0, half counter = 0.
- Note/md latching: sampled live from rhyme/md only at slot entry. Edits to the current slot during playback take effect at the next entry of that slot.
- Half-period H (cycles, middle octave), by note 1..7: 190840, 170068, 151515, 143266, 127551, 113636, 101215.
  - md == 1: H << 1.
  - md == 2: H >> 1.
  - TONE_SHIFT is then applied as a further right-shift.
  - Counter is 20 bits.
  - If the shifted H is 0, it is treated as 1.
- TONE:
  - Half counter counts 0..H-1; buzzer toggles on the cycle the counter equals H-1, and the counter wraps to 0.
  - Note 0 (rest) or note > 7: buzzer held 0, counter idle.
- Slot counter runs 0..NOTE_CYCLES-1 across TONE and GAP.
  - TONE -> GAP when the slot counter reaches NOTE_CYCLES-GAP_CYCLES-1.
  - In GAP: buzzer = 0 and the half counter is cleared.
- End of slot (slot counter == NOTE_CYCLES-1):
  - If play_position+1 < len: advance position, latch the new slot, enter TONE.
  - Otherwise: pulse done for 1 cycle.
    - If repeat: position = 0, latch slot 0, enter TONE.
    - Else: enter IDLE, playing = 0, play_position = 0, buzzer = 0.
- If len shrinks below play_position+1 mid-play, the pass ends at the current slot's end.
- pause high:
  - Slot counter and half counter hold; buzzer forced 0.
  - Resuming continues from the held counts with buzzer restarting low.
  - Ignored in IDLE.
- stop: next cycle IDLE, all outputs 0, no done pulse.
- play while playing: restart at slot 0 (same as from IDLE); no done pulse.
- Reset asserted mid-note: immediate return to reset values.

Test Plan:
- Timing: TONE_SHIFT=10, NOTE_CYCLES=2000, GAP_CYCLES=200; rhyme slot0=1, md=0, how_long=1; pulse play.
  - Required: buzzer toggles every 186 cycles (190840>>10) for 1800 cycles, low for 200 cycles; done pulses at cycle 2000 after entry; playing falls.
- Octaves: same config, slots 0..2 note 6 with md 1, 0, 2; how_long=3.
  - Required: half-periods 221, 110, 55; play_position 0, 1, 2 at 2000-cycle steps.
- Rest and length clamp: slot1 = 0 with how_long=200.
  - Required: buzzer stays 0 throughout slot 1; playback ends after slot 74 with a done pulse.
- Repeat and pause: repeat=1, how_long=2.
  - Required: done pulses at the end of slot 1 and position wraps to 0 with playing still 1.
  - Pause for 500 cycles mid-slot: buzzer 0 and position held; the slot then ends exactly 500 cycles later than without the pause.
- Stop, restart, reset: stop mid-slot gives IDLE next cycle with no done; play mid-slot-3 gives position 0 next cycle; clr low mid-TONE clears outputs asynchronously.
- Zero length: how_long=0 with play.
  - Required: playing stays 0; done pulses once; buzzer 0.
